// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port fixed-priority RAM arbiter with port-1 starvation guard
module dram_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_m0_req,
  input  logic [DW/8-1:0] i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_wdata,
  output logic            o_m0_gnt,
  output logic            o_m0_rvalid,
  output logic [DW-1:0]   o_m0_rdata,
  input  logic            i_m1_req,
  input  logic [DW/8-1:0] i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_wdata,
  output logic            o_m1_gnt,
  output logic            o_m1_rvalid,
  output logic [DW-1:0]   o_m1_rdata,
  output logic [AW-1:0]   o_ram_address,
  output logic [DW-1:0]   o_ram_din,
  output logic            o_ram_rnw,
  output logic [DW/8-1:0] o_ram_cs_b,
  input  logic [DW-1:0]   i_ram_dout
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic [1:0]      rd_pend_q, rd_pend_d;
  logic            gnt0, gnt1;
  logic [DW/8-1:0] sel_we;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_m1_req && (!i_m0_req || starve_cnt_q == STARVE_LIM)) begin
        gnt1 = 1'b1;
      end else if (i_m0_req) begin
        gnt0 = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (i_m1_req && !gnt1) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
    rd_pend_d = {gnt1 & ~|i_m1_we, gnt0 & ~|i_m0_we};
  end

  // Idle cycles present port 0's fields; only cs_b/rnw matter to the RAM then.
  always_comb begin
    sel_we        = gnt1 ? i_m1_we : i_m0_we;
    o_ram_address = gnt1 ? i_m1_addr : i_m0_addr;
    o_ram_din     = gnt1 ? i_m1_wdata : i_m0_wdata;
    o_ram_rnw     = 1'b1;
    o_ram_cs_b    = '1;
    if (gnt0 || gnt1) begin
      o_ram_rnw  = ~|sel_we;
      o_ram_cs_b = (~|sel_we) ? '0 : ~sel_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt_q <= 4'd0;
      rd_pend_q    <= 2'b00;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  // Gating with reset drops a read whose data would land in the reset cycle.
  assign o_m0_gnt    = gnt0;
  assign o_m1_gnt    = gnt1;
  assign o_m0_rvalid = rd_pend_q[0] & ~i_rst;
  assign o_m1_rvalid = rd_pend_q[1] & ~i_rst;
  assign o_m0_rdata  = i_ram_dout;
  assign o_m1_rdata  = i_ram_dout;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter with a byte-select RAM model
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [12:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [12:0] ram_address;
  logic [31:0] ram_din, ram_dout;
  logic        ram_rnw;
  logic [3:0]  ram_cs_b;
  logic [31:0] mem [0:8191];

  int checks = 0;
  int errors = 0;
  logic exp_g0, exp_g1, prev_g0, prev_g1;

  always #5 clk = ~clk;

  dram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
    .o_ram_address(ram_address), .o_ram_din(ram_din), .o_ram_rnw(ram_rnw),
    .o_ram_cs_b(ram_cs_b), .i_ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_cs_b != 4'hF) begin
      if (!ram_rnw) begin
        for (int b = 0; b < 4; b++) begin
          if (!ram_cs_b[b]) mem[ram_address][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
      end else begin
        ram_dout <= mem[ram_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive0(input logic req, input logic [3:0] we, input logic [12:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic [3:0] we, input logic [12:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  initial begin
    ram_dout = 32'h0;
    rst = 1'b1;
    drive0(1'b1, 4'h0, 13'h0, 32'h0);
    drive1(1'b1, 4'h0, 13'h0, 32'h0);

    // reset with both requesting, two cycles
    for (int r = 0; r < 2; r++) begin
      settle();
      chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
      chk("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
      chk("rst_cs_b", {28'd0, ram_cs_b}, 32'hF);
      chk("rst_rnw", {31'd0, ram_rnw}, 32'd1);
      chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      tick();
    end
    rst = 1'b0;
    settle();
    chk("post_rst_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("post_rst_gnt1", {31'd0, m1_gnt}, 32'd0);
    tick();

    // port 0 full-word write then read
    drive1(1'b0, 4'h0, 13'h0, 32'h0);
    drive0(1'b1, 4'hF, 13'h0010, 32'hDEADBEEF);
    settle();
    chk("wr0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("wr0_rnw", {31'd0, ram_rnw}, 32'd0);
    chk("wr0_cs_b", {28'd0, ram_cs_b}, 32'h0);
    chk("wr0_addr", {19'd0, ram_address}, 32'h10);
    chk("wr0_din", ram_din, 32'hDEADBEEF);
    tick();
    drive0(1'b1, 4'h0, 13'h0010, 32'h0);
    settle();
    chk("rd0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rd0_rnw", {31'd0, ram_rnw}, 32'd1);
    chk("rd0_cs_b", {28'd0, ram_cs_b}, 32'h0);
    chk("wr0_no_rvalid", {31'd0, m0_rvalid}, 32'd0);
    tick();
    drive0(1'b0, 4'h0, 13'h0, 32'h0);
    settle();
    chk("rd0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("rd0_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    chk("rd0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("idle_cs_b", {28'd0, ram_cs_b}, 32'hF);
    chk("idle_rnw", {31'd0, ram_rnw}, 32'd1);
    tick();

    // byte write by port 1 into an existing word
    drive0(1'b1, 4'hF, 13'h0020, 32'h11223344);
    tick();
    drive0(1'b0, 4'h0, 13'h0, 32'h0);
    drive1(1'b1, 4'b0100, 13'h0020, 32'h00AA0000);
    settle();
    chk("bw1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("bw1_cs_b", {28'd0, ram_cs_b}, 32'hB);
    chk("bw1_rnw", {31'd0, ram_rnw}, 32'd0);
    tick();
    drive1(1'b1, 4'h0, 13'h0020, 32'h0);
    tick();
    drive1(1'b0, 4'h0, 13'h0, 32'h0);
    settle();
    chk("bw1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("bw1_rdata", m1_rdata, 32'h11AA3344);
    tick();

    // continuous contention: port 1 wins every fifth cycle
    drive0(1'b1, 4'h0, 13'h0010, 32'h0);
    drive1(1'b1, 4'h0, 13'h0020, 32'h0);
    prev_g0 = 1'b0;
    prev_g1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      exp_g1 = (c % 5 == 4);
      exp_g0 = !exp_g1;
      settle();
      chk($sformatf("cont_gnt0_c%0d", c), {31'd0, m0_gnt}, {31'd0, exp_g0});
      chk($sformatf("cont_gnt1_c%0d", c), {31'd0, m1_gnt}, {31'd0, exp_g1});
      if (c > 0) begin
        chk($sformatf("cont_rv0_c%0d", c), {31'd0, m0_rvalid}, {31'd0, prev_g0});
        chk($sformatf("cont_rv1_c%0d", c), {31'd0, m1_rvalid}, {31'd0, prev_g1});
      end
      if (exp_g1) chk($sformatf("cont_starve_max_c%0d", c), {28'd0, dut.starve_cnt_q}, 32'd4);
      prev_g0 = exp_g0;
      prev_g1 = exp_g1;
      tick();
    end
    drive0(1'b0, 4'h0, 13'h0, 32'h0);
    drive1(1'b0, 4'h0, 13'h0, 32'h0);
    settle();
    chk("cont_last_rv1", {31'd0, m1_rvalid}, 32'd1);
    chk("cont_last_rdata", m1_rdata, 32'h11AA3344);
    chk("cont_starve_clr", {28'd0, dut.starve_cnt_q}, 32'd0);
    tick();

    // interleaved reads with distinct data
    drive0(1'b1, 4'hF, 13'h0001, 32'hA5A50001);
    tick();
    drive0(1'b1, 4'hF, 13'h0002, 32'h5A5A0002);
    tick();
    drive0(1'b1, 4'h0, 13'h0001, 32'h0);
    settle();
    chk("il_gnt0", {31'd0, m0_gnt}, 32'd1);
    tick();
    drive0(1'b0, 4'h0, 13'h0, 32'h0);
    drive1(1'b1, 4'h0, 13'h0002, 32'h0);
    settle();
    chk("il_gnt1", {31'd0, m1_gnt}, 32'd1);
    chk("il_n1_rv0", {31'd0, m0_rvalid}, 32'd1);
    chk("il_n1_rv1", {31'd0, m1_rvalid}, 32'd0);
    chk("il_n1_rdata0", m0_rdata, 32'hA5A50001);
    tick();
    drive1(1'b0, 4'h0, 13'h0, 32'h0);
    settle();
    chk("il_n2_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("il_n2_rv1", {31'd0, m1_rvalid}, 32'd1);
    chk("il_n2_rdata1", m1_rdata, 32'h5A5A0002);
    tick();
    settle();
    chk("il_n3_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();

    // partial starvation cleared by reset
    drive0(1'b1, 4'h0, 13'h0, 32'h0);
    drive1(1'b1, 4'h0, 13'h0, 32'h0);
    tick();
    tick();
    chk("starve_two", {28'd0, dut.starve_cnt_q}, 32'd2);
    rst = 1'b1;
    tick();
    chk("starve_rst", {28'd0, dut.starve_cnt_q}, 32'd0);
    rst = 1'b0;
    drive0(1'b0, 4'h0, 13'h0, 32'h0);
    drive1(1'b0, 4'h0, 13'h0, 32'h0);
    tick();

    // reset the cycle after a port-1 read grant
    drive1(1'b1, 4'h0, 13'h0002, 32'h0);
    settle();
    chk("mr_gnt1", {31'd0, m1_gnt}, 32'd1);
    tick();
    drive1(1'b0, 4'h0, 13'h0, 32'h0);
    rst = 1'b1;
    settle();
    chk("mr_rst_rv1", {31'd0, m1_rvalid}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("mr_post_rv1", {31'd0, m1_rvalid}, 32'd0);
    chk("mr_starve", {28'd0, dut.starve_cnt_q}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter that shares the single 8192x32 synchronous data RAM between the CPU data port (port 0) and a secondary bus master such as a DMA engine (port 1). It sits between the requesters and the RAM macro, converting per-port request/byte-enable traffic into the RAM's address, rnw and active-low byte chip selects. It returns read data with a one-cycle valid strobe. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress.

## Interface
Parameters:
- AW, 13, RAM word-address width
- DW, 32, data width; byte lanes = DW/8 = 4
- STARVE_MAX, 4, consecutive port-1 losses before port 1 is forced to win; legal range 1..15

Ports:
- i_clk  in  1  single system clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_m0_req  in  1  port 0 access request; held until o_m0_gnt
- i_m0_we  in  4  port 0 byte write enables; 0 = read
- i_m0_addr  in  AW  port 0 word address
- i_m0_wdata  in  DW  port 0 write data
- o_m0_gnt  out  1  port 0 access accepted this cycle
- o_m0_rvalid  out  1  port 0 read data valid on o_m0_rdata
- o_m0_rdata  out  DW  port 0 read data
- i_m1_req / i_m1_we / i_m1_addr / i_m1_wdata / o_m1_gnt / o_m1_rvalid / o_m1_rdata: port 1, identical to port 0
- o_ram_address  out  AW  RAM word address
- o_ram_din  out  DW  RAM write data
- o_ram_rnw  out  1  1 = read or idle, 0 = write
- o_ram_cs_b  out  4  active-low byte chip selects
- i_ram_dout  in  DW  RAM read data, valid the cycle after the read edge

## Operation
- Requesters hold req, we, addr and wdata stable until gnt. A gnt-cycle completes the access; the requester may drop req or present a new request the next cycle.
- Arbitration is combinational per cycle. At most one gnt is high.
  - Only one port requesting: that port is granted.
  - Both requesting and starve_cnt < STARVE_MAX: port 0 is granted.
  - Both requesting and starve_cnt == STARVE_MAX: port 1 is granted.
- starve_cnt (4 bits, registered):
  - Increments, saturating at STARVE_MAX, when port 1 requests and is not granted.
  - Clears when port 1 is granted or i_m1_req is low.
- RAM drive for the granted port:
  - o_ram_address = addr; o_ram_din = wdata.
  - o_ram_rnw = ~|we.
  - Write: o_ram_cs_b = ~we, so only enabled bytes are selected.
  - Read: o_ram_cs_b = 4'b0000.
- RAM drive when idle (no grant): o_ram_cs_b = 4'b1111, o_ram_rnw = 1, address/din = port 0 fields (don't-care).
- Read return:
  - rd_pend[1:0] registers {m1 granted read, m0 granted read}.
  - o_mX_rvalid = rd_pend[X].
  - o_mX_rdata = i_ram_dout for both ports; it is meaningful only when rvalid is high.
- Writes produce no rvalid.
- Reset (i_rst high, any cycle, including mid-access):
  - gnt outputs forced 0; RAM idle (cs_b 4'b1111, rnw 1).
  - starve_cnt and rd_pend clear at the edge.
  - A read granted in the cycle before reset asserts loses its rvalid.

## Timing
- Grant latency 0: gnt in the same cycle as req when the port wins.
- Read latency 1: grant in cycle N, rvalid and rdata in cycle N+1.
- Throughput one access per cycle. Back-to-back grants to either port are legal, and rvalid may be high in consecutive cycles, alternating between ports.
- A write in cycle N followed by a read of the same address in cycle N+1 returns the new data in N+2.
- Worst-case port-1 wait under continuous port-0 traffic: STARVE_MAX cycles, granted in cycle STARVE_MAX+1 of requesting.
- Output reset values: o_m0_gnt = o_m1_gnt = 0, o_m0_rvalid = o_m1_rvalid = 0, o_ram_cs_b = 4'b1111, o_ram_rnw = 1.

## Test plan
- Reset: assert i_rst for 2 cycles with both reqs high -> both gnt 0, cs_b 4'b1111, rvalid 0; first cycle after release, port 0 granted.
- Single-port write/read:
  - Port 0 writes we=4'b1111, addr 0x0010, data 0xDEADBEEF -> gnt same cycle, rnw 0, cs_b 4'b0000.
  - Port 0 then reads 0x0010 -> rvalid next cycle with rdata 0xDEADBEEF.
- Byte write: port 1 writes we=4'b0100, data 0x00AA0000 to a word holding 0x11223344 -> cs_b 4'b1011; readback 0x11AA3344.
- Contention/starvation, STARVE_MAX=4: both reqs held continuously -> port 0 granted cycles 1-4, port 1 granted cycle 5, starve_cnt returns to 0, pattern repeats every 5 cycles.
- Interleaved reads: port 0 read 0x0001 in cycle N, port 1 read 0x0002 in cycle N+1 -> o_m0_rvalid in N+1 only, o_m1_rvalid in N+2 only, with the correct data for each.
- Reset mid-read: port 1 read granted in cycle N, i_rst high in N+1 -> o_m1_rvalid stays 0 and starve_cnt reads 0 after reset.
